mem_bus_ctrl: RTL and testbench

- MEM-stage external SRAM controller; sits directly downstream of the RAM write-data mux.
- Accepts one load/store request per transaction, with the store word taken from the mux output (`RAM_data`), and runs a multi-cycle asynchronous-SRAM access.
- Stalls the pipeline for the duration of the access and returns read data with a one-cycle response pulse.

---
 rtl/mem_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// MEM-stage asynchronous SRAM controller: one load/store per transaction, pipeline stall, one-cycle response.
// Optional bus turnaround cycle after stores is enabled by defining MEM_BUS_TURNAROUND_EN.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] RAM_data,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  // Strobe length clamped to 1..7; the counter holds (cycles remaining - 1).
  localparam logic [2:0] STROBE_LAST = (WAIT_CYCLES < 1) ? 3'd0 :
                                       (WAIT_CYCLES > 7) ? 3'd6 : 3'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
`ifdef MEM_BUS_TURNAROUND_EN
    HOLD,
    TURN
`else
    HOLD
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_p0;
  logic                we_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic                drive;

  // Accept stage: request fields are captured once and held for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr_p0  <= '0;
      we_p0    <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        addr_p0 <= req_addr;
        we_p0   <= req_we;
      end
      if (state == STROBE && cnt == 3'd0 && !we_p0)
        rsp_data <= ram_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid)
      wdata_p0 <= RAM_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    ram_ce_n  = 1'b1;
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    drive     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        stall     = 1'b1;
        ram_ce_n  = 1'b0;
        drive     = we_p0;
        cnt_nxt   = STROBE_LAST;
        state_nxt = STROBE;
      end
      STROBE: begin
        stall    = 1'b1;
        ram_ce_n = 1'b0;
        drive    = we_p0;
        ram_oe_n = we_p0;
        ram_we_n = !we_p0;
        if (cnt == 3'd0) state_nxt = HOLD;
        else             cnt_nxt   = cnt - 3'd1;
      end
      HOLD: begin
        ram_ce_n  = 1'b0;
        rsp_valid = 1'b1;
        drive     = we_p0;
`ifdef MEM_BUS_TURNAROUND_EN
        state_nxt = we_p0 ? TURN : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef MEM_BUS_TURNAROUND_EN
      // Dead cycle so the controller's bus driver is off before the SRAM can drive.
      TURN: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_addr = addr_p0;
  assign ram_data = drive ? wdata_p0 : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Table-driven bench for mem_bus_ctrl: W=1 instance driven from a vector table, W=3 instance by hand rows.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, v1, we1, rdy1, stl1, rv1, ce1, oe1, wn1;
  logic [15:0] a1, d1, rd1, ad1;
  wire  [15:0] bus1;
  logic        rst3, v3, we3, rdy3, stl3, rv3, ce3, oe3, wn3;
  logic [15:0] a3, d3, rd3, ad3;
  wire  [15:0] bus3;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_we(we1), .req_addr(a1), .RAM_data(d1),
    .req_ready(rdy1), .stall(stl1), .rsp_valid(rv1), .rsp_data(rd1), .ram_addr(ad1),
    .ram_data(bus1), .ram_ce_n(ce1), .ram_oe_n(oe1), .ram_we_n(wn1));

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_we(we3), .req_addr(a3), .RAM_data(d3),
    .req_ready(rdy3), .stall(stl3), .rsp_valid(rv3), .rsp_data(rd3), .ram_addr(ad3),
    .ram_data(bus3), .ram_ce_n(ce3), .ram_oe_n(oe3), .ram_we_n(wn3));

  // Undriven bus reads as 0xFFFF through the pullups.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (bus1[i]);
    pullup (bus3[i]);
  end

  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  always @(posedge clk) begin
    if (!ce1 && !wn1) mem1[ad1[7:0]] <= bus1;
    if (!ce3 && !wn3) mem3[ad3[7:0]] <= bus3;
  end
  assign bus1 = (!ce1 && !oe1 && wn1) ? mem1[ad1[7:0]] : 16'bz;
  assign bus3 = (!ce3 && !oe3 && wn3) ? mem3[ad3[7:0]] : 16'bz;

  typedef struct {
    logic        rst, v, we;
    logic [15:0] a, d;
    logic        rdy, stl, rv, ce, oe, wn;
    logic [15:0] addr, bus, rd;
  } vec_t;

  localparam logic [15:0] Z = 16'hFFFF;
  int total = 0;
  int bad   = 0;
  vec_t tv[$];

  function automatic vec_t mk(input logic r, v, w, input logic [15:0] a, d,
                              input logic rdy, stl, rv, ce, oe, wn,
                              input logic [15:0] addr, bus, rd);
    vec_t t;
    t.rst = r; t.v = v; t.we = w; t.a = a; t.d = d;
    t.rdy = rdy; t.stl = stl; t.rv = rv; t.ce = ce; t.oe = oe; t.wn = wn;
    t.addr = addr; t.bus = bus; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input int idx, input string f, input logic [15:0] got, want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL row%0d %s got=%h want=%h", idx, f, got, want);
    end
  endtask

  // Inputs are applied 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic run(input int inst, input vec_t t, input int idx);
    logic        o_rdy, o_stl, o_rv, o_ce, o_oe, o_wn;
    logic [15:0] o_addr, o_bus, o_rd;
    if (inst == 1) begin
      rst1 = t.rst; v1 = t.v; we1 = t.we; a1 = t.a; d1 = t.d;
    end else begin
      rst3 = t.rst; v3 = t.v; we3 = t.we; a3 = t.a; d3 = t.d;
    end
    #4;
    if (inst == 1) begin
      o_rdy = rdy1; o_stl = stl1; o_rv = rv1; o_ce = ce1; o_oe = oe1; o_wn = wn1;
      o_addr = ad1; o_bus = bus1; o_rd = rd1;
    end else begin
      o_rdy = rdy3; o_stl = stl3; o_rv = rv3; o_ce = ce3; o_oe = oe3; o_wn = wn3;
      o_addr = ad3; o_bus = bus3; o_rd = rd3;
    end
    chk(idx, "req_ready", {15'd0, o_rdy}, {15'd0, t.rdy});
    chk(idx, "stall",     {15'd0, o_stl}, {15'd0, t.stl});
    chk(idx, "rsp_valid", {15'd0, o_rv},  {15'd0, t.rv});
    chk(idx, "ram_ce_n",  {15'd0, o_ce},  {15'd0, t.ce});
    chk(idx, "ram_oe_n",  {15'd0, o_oe},  {15'd0, t.oe});
    chk(idx, "ram_we_n",  {15'd0, o_wn},  {15'd0, t.wn});
    chk(idx, "ram_addr",  o_addr, t.addr);
    chk(idx, "ram_data",  o_bus,  t.bus);
    chk(idx, "rsp_data",  o_rd,   t.rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst1 = 1; v1 = 0; we1 = 0; a1 = 0; d1 = 0;
    rst3 = 1; v3 = 0; we3 = 0; a3 = 0; d3 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1 = 0; rst3 = 0;

    // store 0x1234 <= 0xBEEF, inputs changed after accept
    tv.push_back(mk(0,1,1,16'h1234,16'hBEEF, 1,1,0, 1,1,1, 16'h0000, Z,        16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,1, 16'h1234, 16'hBEEF, 16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,0, 16'h1234, 16'hBEEF, 16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,1, 0,1,1, 16'h1234, 16'hBEEF, 16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h1234, Z,        16'h0000));
    // load 0x1234
    tv.push_back(mk(0,1,0,16'h1234,16'h0000, 1,1,0, 1,1,1, 16'h1234, Z,        16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,1, 16'h1234, Z,        16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,0,1, 16'h1234, 16'hBEEF, 16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,1, 0,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h1234, Z,        16'hBEEF));
    // load with request lines toggled while busy
    tv.push_back(mk(0,1,0,16'h1234,16'h0000, 1,1,0, 1,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h5555,16'h0000, 0,1,0, 0,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,1,1,16'h7777,16'h0000, 0,1,0, 0,0,1, 16'h1234, 16'hBEEF, 16'hBEEF));
    tv.push_back(mk(0,0,0,16'h5555,16'h0000, 0,0,1, 0,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h5555,16'h0000, 1,0,0, 1,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h1234, Z,        16'hBEEF));
    // back-to-back store 0x0010 <= 0x1111 then load 0x0010
    tv.push_back(mk(0,1,1,16'h0010,16'h1111, 1,1,0, 1,1,1, 16'h1234, Z,        16'hBEEF));
    tv.push_back(mk(0,1,1,16'h0010,16'h1111, 0,1,0, 0,1,1, 16'h0010, 16'h1111, 16'hBEEF));
    tv.push_back(mk(0,1,1,16'h0010,16'h1111, 0,1,0, 0,1,0, 16'h0010, 16'h1111, 16'hBEEF));
    tv.push_back(mk(0,1,0,16'h0010,16'h0000, 0,0,1, 0,1,1, 16'h0010, 16'h1111, 16'hBEEF));
`ifdef MEM_BUS_TURNAROUND_EN
    tv.push_back(mk(0,1,0,16'h0010,16'h0000, 0,1,0, 1,1,1, 16'h0010, Z,        16'hBEEF));
`endif
    tv.push_back(mk(0,1,0,16'h0010,16'h0000, 1,1,0, 1,1,1, 16'h0010, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,1, 16'h0010, Z,        16'hBEEF));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,0,1, 16'h0010, 16'h1111, 16'hBEEF));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,0,1, 0,1,1, 16'h0010, Z,        16'h1111));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h0010, Z,        16'h1111));
    // reset held for 2 cycles starting in a store strobe
    tv.push_back(mk(0,1,1,16'h0020,16'h2222, 1,1,0, 1,1,1, 16'h0010, Z,        16'h1111));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,1, 16'h0020, 16'h2222, 16'h1111));
    tv.push_back(mk(1,0,0,16'h0000,16'h0000, 0,1,0, 0,1,0, 16'h0020, 16'h2222, 16'h1111));
    tv.push_back(mk(1,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h0000, Z,        16'h0000));
    tv.push_back(mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h0000, Z,        16'h0000));

    for (int i = 0; i < tv.size(); i++) run(1, tv[i], i);

    // W=3: store 0x0042 <= 0x5A5A
    run(3, mk(0,1,1,16'h0042,16'h5A5A, 1,1,0, 1,1,1, 16'h0000, Z, 16'h0000), 100);
    run(3, mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,1, 16'h0042, 16'h5A5A, 16'h0000), 101);
    for (int k = 0; k < 3; k++)
      run(3, mk(0,0,0,16'h0000,16'h0000, 0,1,0, 0,1,0, 16'h0042, 16'h5A5A, 16'h0000), 102 + k);
    run(3, mk(0,0,0,16'h0000,16'h0000, 0,0,1, 0,1,1, 16'h0042, 16'h5A5A, 16'h0000), 105);
`ifdef MEM_BUS_TURNAROUND_EN
    run(3, mk(0,0,0,16'h0000,16'h0000, 0,1,0, 1,1,1, 16'h0042, Z, 16'h0000), 106);
`endif
    run(3, mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h0042, Z, 16'h0000), 107);
    // W=3: load 0x0042 with address/valid changed after accept
    run(3, mk(0,1,0,16'h0042,16'h0000, 1,1,0, 1,1,1, 16'h0042, Z, 16'h0000), 110);
    run(3, mk(0,1,0,16'h0099,16'h0000, 0,1,0, 0,1,1, 16'h0042, Z, 16'h0000), 111);
    for (int k = 0; k < 3; k++)
      run(3, mk(0,0,0,16'h0099,16'h0000, 0,1,0, 0,0,1, 16'h0042, 16'h5A5A, 16'h0000), 112 + k);
    run(3, mk(0,0,0,16'h0099,16'h0000, 0,0,1, 0,1,1, 16'h0042, Z, 16'h5A5A), 115);
    run(3, mk(0,0,0,16'h0000,16'h0000, 1,0,0, 1,1,1, 16'h0042, Z, 16'h5A5A), 116);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
